// File: rtl/odd_result_pipe.sv
// odd_result_pipe: result staging pipe behind the odd-pipe execute stage.
// Each cycle one 143-bit packet enters stage 1 and shifts toward stage 7, where it retires.
// Every stage drives a forwarding tap. A taken branch squashes the two youngest packets.
// Optional feature: define ODD_RESULT_PERF_EN to add the retire_cnt and squash_cnt counters.
// Packet layout: [127:0] result, [134:128] rt addr, [135] wrt_en,
//                [139:136] unit id, [142:140] latency.
module odd_result_pipe #(
  parameter int unsigned DEPTH   = 7,
  parameter int unsigned PKT_W   = 143,
  parameter int unsigned LAT_LSB = 140
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PKT_W-1:0]  pkt_in,
  input  logic              branch_taken,
  output logic [PKT_W-1:0]  fw_op_st_1,
  output logic [PKT_W-1:0]  fw_op_st_2,
  output logic [PKT_W-1:0]  fw_op_st_3,
  output logic [PKT_W-1:0]  fw_op_st_4,
  output logic [PKT_W-1:0]  fw_op_st_5,
  output logic [PKT_W-1:0]  fw_op_st_6,
  output logic [PKT_W-1:0]  fw_op_st_7,
  output logic [DEPTH-1:0]  fw_ready,
  output logic              rf_wr_en,
  output logic [6:0]        rf_wr_addr,
  output logic [127:0]      rf_wr_data
`ifdef ODD_RESULT_PERF_EN
  ,
  output logic [31:0]       retire_cnt,
  output logic [31:0]       squash_cnt
`endif
);

  localparam int unsigned RES_W    = 128;
  localparam int unsigned ADDR_LSB = 128;
  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned WEN_BIT  = 135;
  localparam int unsigned LAT_W    = 3;
  localparam int unsigned CNT_W    = 32;

  logic [PKT_W-1:0] stage_q [DEPTH];
  logic [PKT_W-1:0] stage_d [DEPTH];

  // A latency of 0 behaves as a latency of 1.
  function automatic logic [LAT_W-1:0] lat_eff(input logic [LAT_W-1:0] lat);
    return (lat == '0) ? LAT_W'(1) : lat;
  endfunction

  // Shift the pipe. A squash clears wrt_en on the incoming packet and on the stage-1 packet.
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      stage_d[k] = '0;
    end
    stage_d[0] = pkt_in;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
    if (branch_taken) begin
      stage_d[0][WEN_BIT] = 1'b0;
      stage_d[1][WEN_BIT] = 1'b0;
    end
  end

  // Stage registers. Reset discards every packet in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  // A stage-k packet can be forwarded once k has reached its effective latency.
  always_comb begin
    fw_ready = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fw_ready[k] = stage_q[k][WEN_BIT] &&
                    (32'(lat_eff(stage_q[k][LAT_LSB +: LAT_W])) <= (k + 32'd1));
    end
  end

  assign fw_op_st_1 = stage_q[0];
  assign fw_op_st_2 = stage_q[1];
  assign fw_op_st_3 = stage_q[2];
  assign fw_op_st_4 = stage_q[3];
  assign fw_op_st_5 = stage_q[4];
  assign fw_op_st_6 = stage_q[5];
  assign fw_op_st_7 = stage_q[6];

  assign rf_wr_en   = stage_q[DEPTH-1][WEN_BIT];
  assign rf_wr_addr = stage_q[DEPTH-1][ADDR_LSB +: ADDR_W];
  assign rf_wr_data = stage_q[DEPTH-1][RES_W-1:0];

`ifdef ODD_RESULT_PERF_EN
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [CNT_W-1:0] squash_q, squash_d;

  // Count retiring writes, and count the live writes that a squash removes.
  always_comb begin
    retire_d = retire_q + CNT_W'(rf_wr_en);
    squash_d = squash_q;
    if (branch_taken) begin
      squash_d = squash_q + CNT_W'(pkt_in[WEN_BIT]) + CNT_W'(stage_q[0][WEN_BIT]);
    end
  end

  // Performance counter registers. Both counters wrap naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retire_q <= '0;
      squash_q <= '0;
    end else begin
      retire_q <= retire_d;
      squash_q <= squash_d;
    end
  end

  assign retire_cnt = retire_q;
  assign squash_cnt = squash_q;
`endif

endmodule

// File: tb/tb_odd_result_pipe.sv
// Self-checking bench for odd_result_pipe: table vectors, directed corner sequences,
// and random traffic compared against a queue-based reference model.
module tb_odd_result_pipe;

  logic          clock = 1'b0;
  logic          reset;
  logic [142:0]  pkt_in;
  logic          branch_taken;
  logic [142:0]  fw1, fw2, fw3, fw4, fw5, fw6, fw7;
  logic [6:0]    fw_ready;
  logic          rf_wr_en;
  logic [6:0]    rf_wr_addr;
  logic [127:0]  rf_wr_data;
`ifdef ODD_RESULT_PERF_EN
  logic [31:0]   retire_cnt, squash_cnt;
`endif

  always #5 clock = ~clock;

  odd_result_pipe dut (
    .clock(clock), .reset(reset), .pkt_in(pkt_in), .branch_taken(branch_taken),
    .fw_op_st_1(fw1), .fw_op_st_2(fw2), .fw_op_st_3(fw3), .fw_op_st_4(fw4),
    .fw_op_st_5(fw5), .fw_op_st_6(fw6), .fw_op_st_7(fw7),
    .fw_ready(fw_ready), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data)
`ifdef ODD_RESULT_PERF_EN
    , .retire_cnt(retire_cnt), .squash_cnt(squash_cnt)
`endif
  );

  logic [142:0] taps [7];
  always_comb begin
    taps[0] = fw1; taps[1] = fw2; taps[2] = fw3; taps[3] = fw4;
    taps[4] = fw5; taps[5] = fw6; taps[6] = fw7;
  end

  int tests = 0;
  int fails = 0;

  // Reference model: a history of presented packets, newest first, with squash marks.
  typedef struct { logic [142:0] pkt; logic sq; } ent_t;
  ent_t hq[$];
  int unsigned m_ret = 0;
  int unsigned m_sq  = 0;

  function automatic logic [142:0] mk(logic [127:0] res, logic [6:0] rt, logic wen,
                                      logic [3:0] uid, logic [2:0] lat);
    return {lat, uid, wen, rt, res};
  endfunction

  // The packet expected in stage k, which is the one presented k edges ago.
  function automatic logic [142:0] exp_stage(int k);
    logic [142:0] p;
    p = '0;
    if (k - 1 < hq.size()) begin
      p = hq[k-1].pkt;
      if (hq[k-1].sq) p[135] = 1'b0;
    end
    return p;
  endfunction

  task automatic chk(string nm, logic [142:0] act, logic [142:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(logic [142:0] p, logic br);
    ent_t e;
    if (hq.size() >= 7 && !hq[6].sq && hq[6].pkt[135]) m_ret++;
    if (br) begin
      if (p[135]) m_sq++;
      if (hq.size() > 0) begin
        if (!hq[0].sq && hq[0].pkt[135]) m_sq++;
        hq[0].sq = 1'b1;
      end
    end
    e.pkt = p;
    e.sq  = br;
    hq.push_front(e);
    if (hq.size() > 7) void'(hq.pop_back());
  endtask

  task automatic check_model();
    logic [142:0] p;
    logic [6:0]   er;
    int           need;
    er = '0;
    for (int k = 1; k <= 7; k++) begin
      p = exp_stage(k);
      chk($sformatf("fw_op_st_%0d", k), taps[k-1], p);
      need = (p[142:140] == 3'd0) ? 1 : int'(p[142:140]);
      if (p[135] && k >= need) er[k-1] = 1'b1;
    end
    chk("fw_ready", 143'(fw_ready), 143'(er));
    p = exp_stage(7);
    chk("rf_wr_en", 143'(rf_wr_en), 143'(p[135]));
    chk("rf_wr_addr", 143'(rf_wr_addr), 143'(p[134:128]));
    chk("rf_wr_data", 143'(rf_wr_data), 143'(p[127:0]));
`ifdef ODD_RESULT_PERF_EN
    chk("retire_cnt", 143'(retire_cnt), 143'(m_ret));
    chk("squash_cnt", 143'(squash_cnt), 143'(m_sq));
`endif
  endtask

  // Called after a negedge: apply the inputs, take one edge, check, return at the next negedge.
  task automatic step(logic [142:0] p, logic br);
    pkt_in       = p;
    branch_taken = br;
    @(posedge clock);
    model_edge(p, br);
    #1;
    check_model();
    @(negedge clock);
  endtask

  // Called after a negedge: assert reset away from any edge, check at once, release at the next negedge.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    hq.delete();
    m_ret = 0;
    m_sq  = 0;
    check_model();
    @(negedge clock);
    reset = 1'b1;
  endtask

  typedef struct {
    string        nm;
    logic [142:0] pkt;
    int           first;   // first stage that reports fw_ready, 0 = never
    logic         wr;
    logic [6:0]   addr;
    logic [127:0] data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [142:0] a, b, c, p;
    logic [6:0]   seen[$];
    logic [6:0]   er;

    reset        = 1'b0;
    pkt_in       = '0;
    branch_taken = 1'b0;

    vecs[0] = '{"retire_l4", mk(128'd20 << 10, 7'd3, 1'b1, 4'd2, 3'd4), 4, 1'b1, 7'd3, 128'd20480};
    vecs[1] = '{"lat0",      mk(128'h55, 7'd9, 1'b1, 4'd1, 3'd0), 1, 1'b1, 7'd9, 128'h55};
    vecs[2] = '{"lat1",      mk(128'hAA, 7'd10, 1'b1, 4'd1, 3'd1), 1, 1'b1, 7'd10, 128'hAA};
    vecs[3] = '{"lat7",      mk(128'h1234, 7'd127, 1'b1, 4'd3, 3'd7), 7, 1'b1, 7'd127, 128'h1234};
    vecs[4] = '{"store",     mk(128'hDEAD, 7'd5, 1'b0, 4'd4, 3'd2), 0, 1'b0, 7'd5, 128'hDEAD};
    vecs[5] = '{"lat2",      mk(128'hF00D, 7'd64, 1'b1, 4'd5, 3'd2), 2, 1'b1, 7'd64, 128'hF00D};

    @(negedge clock);
    do_reset();

    // Table vectors: one packet followed by bubbles, checked at every stage.
    foreach (vecs[i]) begin
      do_reset();
      for (int cyc = 1; cyc <= 7; cyc++) begin
        step((cyc == 1) ? vecs[i].pkt : 143'd0, 1'b0);
        er = (vecs[i].first != 0 && cyc >= vecs[i].first) ? 7'(1 << (cyc - 1)) : 7'd0;
        chk({vecs[i].nm, "_ready"}, 143'(fw_ready), 143'(er));
        if (cyc == 7) begin
          chk({vecs[i].nm, "_wr_en"}, 143'(rf_wr_en), 143'(vecs[i].wr));
          chk({vecs[i].nm, "_addr"}, 143'(rf_wr_addr), 143'(vecs[i].addr));
          chk({vecs[i].nm, "_data"}, 143'(rf_wr_data), 143'(vecs[i].data));
        end
      end
    end

    // Squash: A, B, C back to back, with the branch resolving on the edge that captures C.
    do_reset();
    a = mk(128'hA, 7'd11, 1'b1, 4'd0, 3'd1);
    b = mk(128'hB, 7'd12, 1'b1, 4'd0, 3'd1);
    c = mk(128'hC, 7'd13, 1'b1, 4'd0, 3'd1);
    step(a, 1'b0);
    step(b, 1'b0);
    step(c, 1'b1);
    chk("sq_c_st1_ready", 143'(fw_ready[0]), 143'd0);
    chk("sq_c_st1_tap", fw1, {c[142:136], 1'b0, c[134:0]});
    for (int i = 0; i < 4; i++) step('0, 1'b0);
    chk("sq_a_retire", 143'(rf_wr_en), 143'd1);
    chk("sq_a_addr", 143'(rf_wr_addr), 143'd11);
    step('0, 1'b0);
    chk("sq_b_no_write", 143'(rf_wr_en), 143'd0);
    step('0, 1'b0);
    chk("sq_c_no_write", 143'(rf_wr_en), 143'd0);
`ifdef ODD_RESULT_PERF_EN
    chk("sq_squash_cnt", 143'(squash_cnt), 143'd2);
`endif

    // Back to back: ten writes to rt = 1..10 retire in order.
    do_reset();
    seen.delete();
    for (int i = 0; i < 18; i++) begin
      step((i < 10) ? mk(128'(i * 3 + 1), 7'(i + 1), 1'b1, 4'd6, 3'd3) : 143'd0, 1'b0);
      if (rf_wr_en) seen.push_back(rf_wr_addr);
    end
    chk("b2b_write_count", 143'(seen.size()), 143'd10);
    for (int i = 0; i < seen.size() && i < 10; i++) begin
      chk($sformatf("b2b_addr_%0d", i), 143'(seen[i]), 143'(i + 1));
    end
`ifdef ODD_RESULT_PERF_EN
    chk("b2b_retire_cnt", 143'(retire_cnt), 143'd10);
`endif

    // Reset mid-stream with three packets in flight, then refill.
    do_reset();
    for (int i = 0; i < 3; i++) step(mk(128'(i + 100), 7'(i + 20), 1'b1, 4'd1, 3'd1), 1'b0);
    do_reset();
    chk("rst_fw1_zero", fw1, 143'd0);
    chk("rst_fw3_zero", fw3, 143'd0);
    chk("rst_wr_en_zero", 143'(rf_wr_en), 143'd0);
    p = mk(128'h77, 7'd33, 1'b1, 4'd2, 3'd1);
    step(p, 1'b0);
    chk("rst_refill_fw1", fw1, p);

    // Random traffic against the model, with occasional branches and resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 96) == 0) begin
        do_reset();
      end else begin
        p = 143'({$urandom, $urandom, $urandom, $urandom, $urandom});
        step(p, ($urandom_range(0, 5) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
